// File: rtl/console_writer.sv
// Character-stream front end for a text-mode framebuffer with cursor, wrap and scroll.
// Optional CONSOLE_FORMFEED_EN: 0x0C clears the screen with the byte's colours and homes.
module console_writer #(
    parameter int         COLS       = 160,
    parameter int         ROWS       = 45,
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [11:0] DEF_FG    = 12'hFFF,
    parameter logic [11:0] DEF_BG    = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic [11:0] fg,
    input  logic [11:0] bg,
    output logic [7:0]  write_posx,
    output logic [5:0]  write_posy,
    output logic [31:0] write_value,
    output logic        write_enable,
    output logic [5:0]  v_offset
);

    localparam logic [7:0] XMAX  = 8'(COLS - 1);
    localparam logic [8:0] XLAST = 9'(COLS - 1);
    localparam logic [8:0] XEND  = 9'(COLS);
    localparam logic [5:0] YLAST = 6'(ROWS - 1);
    localparam logic [6:0] ROWS7 = 7'(ROWS);

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [8:0]  cx_q, cx_d;
    logic [5:0]  cy_q, cy_d;
    logic [23:0] col_q, col_d;
    logic        we_q, we_d;
    logic [7:0]  posx_q, posx_d;
    logic [5:0]  posy_q, posy_d;
    logic [31:0] value_q, value_d;
    logic [5:0]  voff_q, voff_d;
    logic        rdy_q, rdy_d;
    logic        nl;

    function automatic logic [5:0] phys(input logic [5:0] row, input logic [5:0] off);
        logic [6:0] sum;
        sum = {1'b0, row} + {1'b0, off};
        if (sum >= ROWS7) sum = sum - ROWS7;
        return sum[5:0];
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        we_d    = 1'b0;
        posx_d  = posx_q;
        posy_d  = posy_q;
        value_d = value_q;
        voff_d  = voff_q;
        rdy_d   = rdy_q;
        nl      = 1'b0;
        unique case (state_q)
            CLR_ALL: begin
                rdy_d   = 1'b0;
                we_d    = 1'b1;
                posx_d  = cx_q[7:0];
                posy_d  = cy_q;
                value_d = {col_q, BLANK_CHAR};
                if (cx_q == XLAST) begin
                    cx_d = '0;
                    if (cy_q == YLAST) begin
                        cy_d    = '0;
                        state_d = IDLE;
                        x_d     = '0;
                        y_d     = '0;
                        voff_d  = '0;
                    end else begin
                        cy_d = cy_q + 6'd1;
                    end
                end else begin
                    cx_d = cx_q + 9'd1;
                end
            end
            IDLE: begin
                rdy_d = 1'b1;
                if (char_valid && rdy_q) begin
                    col_d = {fg, bg};
                    case (char_data)
                        8'h0D: x_d = '0;
                        8'h0A: begin
                            x_d = '0;
                            nl  = 1'b1;
                        end
                        8'h08: begin
                            if (x_q != 8'd0) begin
                                x_d     = x_q - 8'd1;
                                we_d    = 1'b1;
                                posx_d  = x_q - 8'd1;
                                posy_d  = phys(y_q, voff_q);
                                value_d = {fg, bg, BLANK_CHAR};
                            end
                        end
`ifdef CONSOLE_FORMFEED_EN
                        8'h0C: begin
                            state_d = CLR_ALL;
                            rdy_d   = 1'b0;
                            cx_d    = '0;
                            cy_d    = '0;
                        end
`endif
                        default: begin
                            we_d    = 1'b1;
                            posx_d  = x_q;
                            posy_d  = phys(y_q, voff_q);
                            value_d = {fg, bg, char_data};
                            if (x_q == XMAX) begin
                                x_d = '0;
                                nl  = 1'b1;
                            end else begin
                                x_d = x_q + 8'd1;
                            end
                        end
                    endcase
                    // Bottom row full: recycle the oldest physical row instead of moving down
                    if (nl) begin
                        if (y_q != YLAST) begin
                            y_d = y_q + 6'd1;
                        end else begin
                            state_d = CLR_ROW;
                            rdy_d   = 1'b0;
                            cx_d    = '0;
                        end
                    end
                end
            end
            CLR_ROW: begin
                rdy_d = 1'b0;
                if (cx_q == XEND) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    cx_d    = '0;
                    voff_d  = (voff_q == YLAST) ? 6'd0 : voff_q + 6'd1;
                end else begin
                    we_d    = 1'b1;
                    posx_d  = cx_q[7:0];
                    posy_d  = voff_q;
                    value_d = {col_q, BLANK_CHAR};
                    cx_d    = cx_q + 9'd1;
                end
            end
            default: state_d = CLR_ALL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_ALL;
            x_q     <= '0;
            y_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= {DEF_FG, DEF_BG};
            we_q    <= 1'b0;
            posx_q  <= '0;
            posy_q  <= '0;
            value_q <= '0;
            voff_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            we_q    <= we_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            value_q <= value_d;
            voff_q  <= voff_d;
            rdy_q   <= rdy_d;
        end
    end

    assign char_ready   = rdy_q;
    assign write_enable = we_q;
    assign write_posx   = posx_q;
    assign write_posy   = posy_q;
    assign write_value  = value_q;
    assign v_offset     = voff_q;

endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: directed steps plus random bytes against a
// logical-screen model (lines shift up on scroll, display maps via v_offset).
module tb_console_writer;

    localparam int COLS = 160;
    localparam int ROWS = 45;
    localparam logic [31:0] CLR_V = 32'hFFF00020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic [11:0] fg = 12'h000;
    logic [11:0] bg = 12'h000;
    logic [7:0]  write_posx;
    logic [5:0]  write_posy;
    logic [31:0] write_value;
    logic        write_enable;
    logic [5:0]  v_offset;

    console_writer dut (
        .clk(clk), .rst(rst),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .fg(fg), .bg(bg),
        .write_posx(write_posx), .write_posy(write_posy),
        .write_value(write_value), .write_enable(write_enable),
        .v_offset(v_offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [31:0] v;
        int          c;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] dut_mem [64][256];
    logic [31:0] scr [ROWS][COLS];
    int          mx, my, mvo;
    int          cyc = 0;
    int          bad_addr = 0;
    int          passed = 0;
    int          total = 0;

    // Write-port monitor: records every strobe and mirrors it into a memory image
    always @(posedge clk) begin
        #1;
        cyc++;
        if (write_enable) begin
            if (write_posx >= 8'(COLS) || write_posy >= 6'(ROWS)) bad_addr++;
            else dut_mem[write_posy][write_posx] = write_value;
            wq.push_back('{x: int'(write_posx), y: int'(write_posy),
                           v: write_value, c: cyc});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = CLR_V;
        mx = 0;
        my = 0;
        mvo = 0;
    endtask

    task automatic model_nl(input logic [11:0] f, input logic [11:0] g);
        if (my < ROWS - 1) begin
            my++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = {f, g, 8'h20};
            mvo = (mvo + 1) % ROWS;
        end
    endtask

    task automatic model_apply(input logic [7:0] b, input logic [11:0] f, input logic [11:0] g);
        if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            mx = 0;
            model_nl(f, g);
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                scr[my][mx] = {f, g, 8'h20};
            end
        end else begin
            scr[my][mx] = {f, g, b};
            if (mx == COLS - 1) begin
                mx = 0;
                model_nl(f, g);
            end else begin
                mx++;
            end
        end
    endtask

    function automatic int mem_mism();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (dut_mem[(r + mvo) % ROWS][c] !== scr[r][c]) n++;
        return n;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!char_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk(tag, 64'(n), 64'd0);
    endtask

    task automatic send(input logic [7:0] b, input logic [11:0] f, input logic [11:0] g);
        char_valid = 1'b1;
        char_data = b;
        fg = f;
        bg = g;
        wait_ready("send_timeout");
        @(negedge clk);
        char_valid = 1'b0;
        char_data = 8'($urandom);
        fg = 12'($urandom);
        bg = 12'($urandom);
        model_apply(b, f, g);
    endtask

    task automatic full_clear_check(input string tag);
        int n = 0;
        int viol = 0;
        int bad = 0;
        while (n < 8000) begin
            @(negedge clk);
            n++;
            if (write_enable && char_ready) viol++;
            if (char_ready) break;
        end
        chk({tag, "_ready"}, 64'(char_ready), 64'd1);
        chk({tag, "_count"}, 64'(wq.size()), 64'(ROWS * COLS));
        chk({tag, "_rdy_low"}, 64'(viol), 64'd0);
        for (int k = 0; k < wq.size(); k++)
            if (wq[k].x != k % COLS || wq[k].y != k / COLS || wq[k].v !== CLR_V) bad++;
        chk({tag, "_cells"}, 64'(bad), 64'd0);
        wq.delete();
    endtask

    function automatic logic [7:0] rbyte();
        int r = int'($urandom_range(0, 99));
        if (r < 8) return 8'h0A;
        if (r < 12) return 8'h0D;
        if (r < 20) return 8'h08;
        return 8'($urandom_range(32, 255));
    endfunction

    initial begin
        wr_t w0, w1;
        int  n, bad;
        logic [7:0] b;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_rdy", 64'(char_ready), 64'd0);
        chk("rst_voff", 64'(v_offset), 64'd0);
        chk("rst_posx", 64'(write_posx), 64'd0);
        chk("rst_posy", 64'(write_posy), 64'd0);
        chk("rst_value", 64'(write_value), 64'd0);
        wq.delete();
        rst = 1'b0;
        full_clear_check("clr");
        model_reset();

        // Two back-to-back printable bytes
        send(8'h41, 12'hF00, 12'h00F);
        send(8'h42, 12'hF00, 12'h00F);
        chk("print_n", 64'(wq.size()), 64'd2);
        w0 = wq.pop_front();
        w1 = wq.pop_front();
        chk("print_A", {w0.x[7:0], w0.y[5:0], w0.v}, {8'd0, 6'd0, 32'hF0000F41});
        chk("print_B", {w1.x[7:0], w1.y[5:0], w1.v}, {8'd1, 6'd0, 32'hF0000F42});
        chk("print_consec", 64'(w1.c - w0.c), 64'd1);
        send(8'h43, 12'h0F0, 12'h000);
        w0 = wq.pop_front();
        chk("cursor_x2", 64'(w0.x), 64'd2);

        // Wrap at the last column
        send(8'h0D, 12'h000, 12'h000);
        for (int i = 0; i < 161; i++) send(8'($urandom_range(32, 126)), 12'h0AA, 12'h055);
        chk("wrap_n", 64'(wq.size()), 64'd161);
        chk("wrap_160", {32'(wq[159].x), 32'(wq[159].y)}, {32'd159, 32'd0});
        chk("wrap_161", {32'(wq[160].x), 32'(wq[160].y)}, {32'd0, 32'd1});
        wq.delete();

        // Scroll from the bottom row
        while (my < ROWS - 1) send(8'h0A, 12'h000, 12'h000);
        wq.delete();
        chk("pre_scroll_voff", 64'(v_offset), 64'd0);
        send(8'h0A, 12'h123, 12'h456);
        n = 0;
        while (!char_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("scroll_stall", 64'(n), 64'd161);
        chk("scroll_n", 64'(wq.size()), 64'(COLS));
        bad = 0;
        for (int k = 0; k < wq.size(); k++)
            if (wq[k].x != k || wq[k].y != 0 || wq[k].v !== 32'h12345620) bad++;
        chk("scroll_row0", 64'(bad), 64'd0);
        chk("scroll_voff", 64'(v_offset), 64'd1);
        wq.delete();
        send(8'h58, 12'hABC, 12'hDEF);
        w0 = wq.pop_front();
        chk("after_scroll_X", {w0.x[7:0], w0.y[5:0], w0.v}, {8'd0, 6'd0, 32'hABCDEF58});
        chk("screen_a", 64'(mem_mism()), 64'd0);

        // Drive v_offset around to ROWS-1 and past it
        while (mvo != ROWS - 1) send(8'h0A, 12'h111, 12'h222);
        wait_ready("voff_timeout");
        chk("voff_44", 64'(v_offset), 64'd44);
        wq.delete();
        send(8'h0A, 12'h321, 12'h654);
        wait_ready("voff_wrap_timeout");
        bad = 0;
        for (int k = 0; k < wq.size(); k++) if (wq[k].y != 44) bad++;
        chk("voff_wrap_row", {32'(wq.size()), 32'(bad)}, {32'(COLS), 32'd0});
        chk("voff_wrap", 64'(v_offset), 64'd0);
        wq.delete();

        // Random byte stream against the screen model
        for (int i = 0; i < 400; i++) begin
            b = rbyte();
            send(b, 12'($urandom), 12'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_ready("rand_timeout");
        chk("rand_voff", 64'(v_offset), 64'(mvo));
        chk("rand_screen", 64'(mem_mism()), 64'd0);
        wq.delete();

        // Backspace, and backspace at column 0
        send(8'h0D, 12'h000, 12'h000);
        send(8'h51, 12'h777, 12'h888);
        send(8'h08, 12'h345, 12'h678);
        chk("bs_n", 64'(wq.size()), 64'd2);
        w1 = wq[1];
        chk("bs_blank", {w1.x[7:0], w1.y[5:0], w1.v},
            {8'd0, 6'((my + mvo) % ROWS), 32'h34567820});
        wq.delete();
        send(8'h08, 12'h345, 12'h678);
        repeat (3) @(negedge clk);
        chk("bs_x0_nowrite", 64'(wq.size()), 64'd0);
        chk("bs_screen", 64'(mem_mism()), 64'd0);

        // Reset in the middle of a row clear
        while (my < ROWS - 1) send(8'h0A, 12'h000, 12'h000);
        send(8'h0A, 12'h999, 12'h999);
        repeat (50) @(negedge clk);
        chk("mid_clr_busy", 64'(char_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        wq.delete();
        chk("mid_rst_we", 64'(write_enable), 64'd0);
        chk("mid_rst_voff", 64'(v_offset), 64'd0);
        rst = 1'b0;
        n = 0;
        while (wq.size() == 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_wr", 64'(wq.size() > 0), 64'd1);
        if (wq.size() > 0) begin
            w0 = wq[0];
            chk("mid_rst_first", {w0.x[7:0], w0.y[5:0], w0.v}, {8'd0, 6'd0, CLR_V});
        end
        full_clear_check("clr2");
        model_reset();
        chk("clr2_voff", 64'(v_offset), 64'd0);
        chk("clr2_screen", 64'(mem_mism()), 64'd0);
        chk("addr_range", 64'(bad_addr), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
